// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants for the VGA timing generator.
// Optional VGA_TEST_PATTERN_EN build adds a colour-bar test mode.
package vga_timing_pkg;

    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int PIPE_DELAY = 2;

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic HS_ACT = 1'b0;
    localparam logic VS_ACT = 1'b0;

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register with a synchronous reset value.
// Used to align sync/enable with the pixel fetch latency.
module vga_sync_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= rst_val;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator with latency-matched sync/DE/RGB.
// Define VGA_TEST_PATTERN_EN for the test_mode colour-bar input.
module vga_timing_gen #(
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int PIPE_DELAY = vga_timing_pkg::PIPE_DELAY
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        vga_blank_n,
    input  logic [23:0] pixel_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        frame_start
);

    import vga_timing_pkg::*;

    localparam int H_BLK = H_FP + H_SYNC + H_BP;
    localparam int H_TOT = H_BLK + H_ACTIVE;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] HS_S    = 10'(H_FP);
    localparam logic [9:0] HS_E    = 10'(H_FP + H_SYNC);
    localparam logic [9:0] VS_S    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_E    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
    localparam logic [9:0] DE_S    = 10'(H_BLK - PIPE_DELAY);
    localparam logic [9:0] DE_E    = 10'(H_TOT - PIPE_DELAY);

    logic hs_raw;
    logic vs_raw;
    logic hs_d;
    logic vs_d;
    logic de_d;
    logic [23:0] px;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (hcount == H_LAST) && (vcount == V_LAST);
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    assign hs_raw = (hcount >= HS_S && hcount < HS_E) ? HS_ACT : ~HS_ACT;
    assign vs_raw = (vcount >= VS_S && vcount < VS_E) ? VS_ACT : ~VS_ACT;

    // Opens PIPE_DELAY early so fetched pixels land on the visible window
    assign vga_blank_n = (vcount < V_VIS) && (hcount >= DE_S) && (hcount < DE_E);

`ifdef VGA_TEST_PATTERN_EN
    // Bar index is taken from the column the fetch is aimed at
    localparam logic [9:0] COL_OFS = 10'(PIPE_DELAY - H_BLK);

    logic [2:0] bar_raw;
    logic [2:0] bar_d;

    assign bar_raw = 3'((hcount + COL_OFS) >> 7);

    vga_sync_delay #(
        .DEPTH (PIPE_DELAY),
        .WIDTH (6)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val ({3'b000, ~HS_ACT, ~VS_ACT, 1'b0}),
        .d       ({bar_raw, hs_raw, vs_raw, vga_blank_n}),
        .q       ({bar_d, hs_d, vs_d, de_d})
    );

    assign px = test_mode ? {{8{bar_d[2]}}, {8{bar_d[1]}}, {8{bar_d[0]}}}
                          : pixel_in;
`else
    vga_sync_delay #(
        .DEPTH (PIPE_DELAY),
        .WIDTH (3)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val ({~HS_ACT, ~VS_ACT, 1'b0}),
        .d       ({hs_raw, vs_raw, vga_blank_n}),
        .q       ({hs_d, vs_d, de_d})
    );

    assign px = pixel_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_hs <= ~HS_ACT;
            vga_vs <= ~VS_ACT;
            vga_de <= 1'b0;
            {vga_r, vga_g, vga_b} <= 24'h0;
        end else begin
            vga_hs <= hs_d;
            vga_vs <= vs_d;
            vga_de <= de_d;
            {vga_r, vga_g, vga_b} <= de_d ? px : 24'h0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a short vertical frame.
// Build with VGA_TEST_PATTERN_EN to also exercise the colour bars.
module tb_vga_timing_gen;

    localparam int VA    = 4;
    localparam int VF    = 2;
    localparam int VSY   = 2;
    localparam int VB    = 2;
    localparam int HT    = 800;
    localparam int VT    = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        vga_blank_n;
    logic [23:0] pixel_in;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic        frame_start;
    logic [23:0] p1;
    logic [23:0] p2;
    logic [23:0] rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VSY),
        .V_BP     (VB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .vga_blank_n (vga_blank_n),
        .pixel_in    (pixel_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .frame_start (frame_start)
    );

    // Address-generator model: returns the colour of the column it was
    // asked for (hcount + 2) two clocks later.
    always @(posedge clk) begin
        p1 <= 24'(hcount) + 24'd2;
        p2 <= p1;
    end
    assign pixel_in = p2;
    assign rgb = {vga_r, vga_g, vga_b};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_at(input logic [9:0] h, input logic [9:0] v,
                            input logic exp_hs, input logic exp_vs,
                            input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20000 && !found; k++) begin
            @(negedge clk);
            if (hcount == h && vcount == v) found = 1'b1;
        end
        check({tag, "_reach"}, 32'(found), 32'd1);
        check({tag, "_pre_hs"}, 32'(vga_hs), 32'(exp_hs));
        check({tag, "_pre_vs"}, 32'(vga_vs), 32'(exp_vs));
        rst_n = 1'b0;
        @(negedge clk);
        check({tag, "_hcount"}, 32'(hcount), 32'd0);
        check({tag, "_vcount"}, 32'(vcount), 32'd0);
        check({tag, "_hs"}, 32'(vga_hs), 32'd1);
        check({tag, "_vs"}, 32'(vga_vs), 32'd1);
        check({tag, "_de"}, 32'(vga_de), 32'd0);
        check({tag, "_rgb"}, 32'(rgb), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int hs_fall[$];
        int vs_fall[$];
        int fs[$];
        int hs_rise;
        int vs_rise;
        int de_line[VT];
        int de_blank;
        int bad_rgb;
        int bad_zero;
        logic prev_hs;
        logic prev_vs;

        hs_rise  = 0;
        vs_rise  = 0;
        de_blank = 0;
        bad_rgb  = 0;
        bad_zero = 0;
        prev_hs  = 1'b1;
        prev_vs  = 1'b1;
        foreach (de_line[i]) de_line[i] = 0;

        rst_n = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_hcount", 32'(hcount), 32'd0);
        check("rst_vcount", 32'(vcount), 32'd0);
        check("rst_hs", 32'(vga_hs), 32'd1);
        check("rst_vs", 32'(vga_vs), 32'd1);
        check("rst_de", 32'(vga_de), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        rst_n = 1'b1;

        for (int n = 1; n <= 2 * FRAME + 100; n++) begin
            @(negedge clk);
            if (n <= 3) check("hcount_run", 32'(hcount), 32'(n));
            if (prev_hs && !vga_hs) hs_fall.push_back(n);
            if (!prev_hs && vga_hs && hs_rise == 0) hs_rise = n;
            if (prev_vs && !vga_vs) vs_fall.push_back(n);
            if (!prev_vs && vga_vs && vs_rise == 0) vs_rise = n;
            if (frame_start) fs.push_back(n);
            if (n == 160) check("de_before", 32'(vga_de), 32'd0);
            if (n == 161) begin
                check("de_first", 32'(vga_de), 32'd1);
                check("rgb_first", 32'(rgb), 32'h0000A0);
            end
            if (n == 800) begin
                check("de_last", 32'(vga_de), 32'd1);
                check("rgb_last", 32'(rgb), 32'h00031F);
            end
            if (n == 801) check("de_after", 32'(vga_de), 32'd0);
            if (vga_de) begin
                if (n <= FRAME) begin
                    if ((n - 3) / HT < VA) de_line[(n - 3) / HT]++;
                    else de_blank++;
                end
                if (rgb !== 24'((n - 1) % HT)) bad_rgb++;
            end else if (rgb !== 24'h0) begin
                bad_zero++;
            end
            prev_hs = vga_hs;
            prev_vs = vga_vs;
        end

        check("hs_first_fall", 32'(hs_fall.size() > 0 ? hs_fall[0] : -1), 32'd19);
        check("hs_width", 32'(hs_rise - (hs_fall.size() > 0 ? hs_fall[0] : 0)), 32'd96);
        check("hs_period", 32'(hs_fall.size() > 1 ? hs_fall[1] - hs_fall[0] : -1), 32'd800);
        check("vs_first_fall", 32'(vs_fall.size() > 0 ? vs_fall[0] : -1), 32'd4803);
        check("vs_width", 32'(vs_rise - (vs_fall.size() > 0 ? vs_fall[0] : 0)), 32'd1600);
        check("vs_period", 32'(vs_fall.size() > 1 ? vs_fall[1] - vs_fall[0] : -1), 32'(FRAME));
        check("fs_count", 32'(fs.size()), 32'd2);
        check("fs_first", 32'(fs.size() > 0 ? fs[0] : -1), 32'(FRAME));
        check("fs_period", 32'(fs.size() > 1 ? fs[1] - fs[0] : -1), 32'(FRAME));
        check("de_line0", 32'(de_line[0]), 32'd640);
        check("de_line_last", 32'(de_line[VA-1]), 32'd640);
        check("de_vblank", 32'(de_blank), 32'd0);
        check("rgb_track", 32'(bad_rgb), 32'd0);
        check("rgb_blank_zero", 32'(bad_zero), 32'd0);

        reset_at(10'd400, 10'd2, 1'b1, 1'b1, "rst_mid");
        @(negedge clk);
        check("rst_mid_restart", 32'(hcount), 32'd1);
        reset_at(10'd50, 10'd7, 1'b0, 1'b0, "rst_sync");

`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b1;
        for (int n = 1; n <= 700; n++) begin
            @(negedge clk);
            if (n == 160) check("tp_pre", 32'(rgb), 32'h0);
            if (n == 161) check("tp_x0", 32'(rgb), 32'h000000);
            if (n == 288) check("tp_x127", 32'(rgb), 32'h000000);
            if (n == 289) check("tp_x128", 32'(rgb), 32'h0000FF);
            if (n == 545) check("tp_x384", 32'(rgb), 32'h00FFFF);
            if (n == 673) check("tp_x512", 32'(rgb), 32'hFF0000);
        end
        test_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
